// File: rtl/accum_bank.sv
// accum_bank: multi-channel signed accumulator bank with sticky overflow flags, a 2-stage
// command pipeline and a sequenced clear-all sweep. Define ACCUM_SATURATE_EN to saturate on overflow.
module accum_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ATTR_WIDTH = 4,
    parameter int CHANNELS   = 4,
    parameter int SIGN       = 0,
    parameter int OVERFLOW   = 1,
    localparam int CW        = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CW-1:0]         in_chan,
    input  logic                  in_init,
    input  logic                  in_neg,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ATTR_WIDTH-1:0] in_attr,
    input  logic                  rd_en,
    input  logic [CW-1:0]         rd_chan,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_VAL = ~MIN_VAL;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         ptr;
    logic                  clr_en;
    logic                  accept;

    logic [DATA_WIDTH-1:0] acc [CHANNELS];
    logic [CHANNELS-1:0]   sticky;

    logic                  s1_valid, s1_init, s1_nflag, s1_aflag;
    logic [CW-1:0]         s1_chan;
    logic [DATA_WIDTH-1:0] s1_operand;

    logic [DATA_WIDTH-1:0] base, sum, result;
    logic                  aovf, arith_ovf, ovf;
    logic [ATTR_WIDTH-1:0] rd_attr;
    logic                  unused_attr;

    assign unused_attr = ^in_attr;
    assign accept      = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear_req) state_next = CLEAR;
            CLEAR:   if (ptr == CW'(CHANNELS - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state == CLEAR);
        clr_en   = (state == CLEAR);
    end

    // Pointer rests at 0 while idle so the sweep always starts at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 ptr <= '0;
        else if (state == IDLE)  ptr <= '0;
        else                     ptr <= ptr + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_chan    <= '0;
            s1_init    <= 1'b0;
            s1_operand <= '0;
            s1_nflag   <= 1'b0;
            s1_aflag   <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_chan    <= in_chan;
                s1_init    <= in_init;
                s1_operand <= in_neg ? (-in_data) : in_data;
                s1_nflag   <= in_neg && (in_data == MIN_VAL);
                s1_aflag   <= in_attr[OVERFLOW];
            end
        end
    end

    // Negating MIN wraps back to MIN, so its true magnitude 2^(W-1) is re-added for the sign decision.
`ifdef ACCUM_SATURATE_EN
    logic [DATA_WIDTH:0] true_sum;
    always_comb begin
        true_sum = {base[MSB], base} +
                   (s1_nflag ? {2'b01, {(DATA_WIDTH-1){1'b0}}} : {s1_operand[MSB], s1_operand});
    end
`endif

    always_comb begin
        base      = s1_init ? '0 : acc[s1_chan];
        sum       = base + s1_operand;
        aovf      = (base[MSB] == s1_operand[MSB]) && (sum[MSB] != base[MSB]);
        arith_ovf = aovf | s1_nflag;
        ovf       = arith_ovf | s1_aflag;
`ifdef ACCUM_SATURATE_EN
        result    = arith_ovf ? (true_sum[DATA_WIDTH] ? MIN_VAL : MAX_VAL) : sum;
`else
        result    = sum;
`endif
    end

    // The sweep clear is applied after the pipeline write so it wins on a shared channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
            sticky <= '0;
        end else begin
            if (s1_valid) begin
                acc[s1_chan]    <= result;
                sticky[s1_chan] <= s1_init ? ovf : (sticky[s1_chan] | ovf);
            end
            if (clr_en) begin
                acc[ptr]    <= '0;
                sticky[ptr] <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_attr           = '0;
        rd_attr[SIGN]     = acc[rd_chan][MSB];
        rd_attr[OVERFLOW] = sticky[rd_chan];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            attr_out <= '0;
        end else if (rd_en) begin
            data_out <= acc[rd_chan];
            attr_out <= rd_attr;
        end else begin
            data_out <= '0;
            attr_out <= '0;
        end
    end

endmodule
